ewrapper_emesh_arbiter: RTL
===========================

EWRAPPER_EMESH_ARBITER -- requirements
Module: ewrapper_emesh_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 8, range 1..15: maximum consecutive transfers granted to one requester while the other is requesting.
REQ-002 The block SHALL use one clock, emesh_clk_inb; reset is synchronous and active-high, named reset.
REQ-003 emesh_clk_inb  in  1  sole clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req0_access  in  1  requester 0 packet valid; held until accepted.
REQ-006 req0_write in 1; req0_datamode in 2; req0_ctrlmode in 4; req0_dstaddr in 32; req0_srcaddr in 32; req0_data in 32: requester 0 packet fields.
REQ-007 req0_wr_wait, req0_rd_wait  out  1 each  requester 0 stall.
REQ-008 req1_* ports SHALL be identical to req0_* ports and serve requester 1.
REQ-009 emesh_access_outb, emesh_write_outb, emesh_datamode_outb[1:0], emesh_ctrlmode_outb[3:0], emesh_dstaddr_outb[31:0], emesh_srcaddr_outb[31:0], emesh_data_outb[31:0]  out: registered packet to the link transmitter.
REQ-010 emesh_wr_wait_inb, emesh_rd_wait_inb  in  1 each  link transmitter stall for write and read packets.

Function
REQ-011 Upstream transfer SHALL occur on a cycle with reqN_access=1 and reqN wait=0; the requester holds all fields stable while waiting.
REQ-012 Downstream transfer SHALL occur on a cycle with emesh_access_outb=1 and relevant wait=0, where relevant wait is emesh_wr_wait_inb if emesh_write_outb=1, else emesh_rd_wait_inb.
REQ-013 One output slot SHALL hold a packet; slot_free = !slot_valid OR downstream transfer this cycle.
REQ-014 State SHALL be IDLE, OWN0 or OWN1, plus a 4-bit saturating burst counter cnt and a last_owner bit.
REQ-015 Grant selection: in OWNk, grant k if req_k access and (cnt<BURST_MAX or other not requesting); else grant other if requesting; else none.
REQ-016 In IDLE: single requester is granted; both requesting grants the requester that is not last_owner.
REQ-017 accept_N = grant_N AND slot_free; reqN_wr_wait = reqN_rd_wait = !accept_N (combinational, includes path from emesh_*_wait_inb).
REQ-018 On accept_N: slot loads the req N packet, state becomes OWNN, last_owner=N, cnt = (previous state OWNN) ? min(cnt+1,15) : 1.
REQ-019 No accept and owner's access low: state SHALL go to IDLE, cnt=0; no accept because slot full: state and cnt unchanged.
REQ-020 Downstream transfer without new accept SHALL clear slot_valid next cycle; simultaneous drain and accept SHALL keep slot_valid=1 with the new packet (zero-bubble throughput, one packet per cycle).
REQ-021 Latency: packet accepted on cycle t appears on emesh_*_outb on cycle t+1.
REQ-022 emesh_access_outb SHALL equal slot_valid; packet fields SHALL remain stable while the slot is stalled.

Reset
REQ-023 reset SHALL set: state IDLE, cnt 0, last_owner 1 (requester 0 wins first tie), slot_valid 0, all emesh_*_outb 0.
REQ-024 Reset mid-operation SHALL discard the slot packet; wait outputs reflect post-reset state the following cycle.

Structure
REQ-025 State encoding, packet field widths (103-bit packet) and BURST_MAX bounds SHALL live in a shared ewrapper package.
REQ-026 Grant logic SHALL be a sub-module ewrapper_rr_grant (state/cnt/last_owner/accesses in, grant vector out); slot and state registers remain in the top.

Verification
REQ-027 Only req0 streams 20 writes, waits low -> 20 packets out, one per cycle, latency 1, req0_wr_wait=0 throughout.
REQ-028 Both stream continuously, BURST_MAX=4 -> output owner sequence 0,0,0,0,1,1,1,1,0... ; no packet lost or duplicated.
REQ-029 Slot holds write, emesh_wr_wait_inb=1 for 5 cycles -> outputs stable 5 cycles, req0/req1 waits=1; wait drop -> drain and next accept same cycle.
REQ-030 Slot holds read, emesh_wr_wait_inb=1, emesh_rd_wait_inb=0 -> read drains immediately.
REQ-031 Simultaneous first request after reset -> req0 granted, req1_rd_wait=1 that cycle.
REQ-032 reset asserted with slot valid and state OWN1 -> next cycle emesh_access_outb=0, state IDLE, cnt=0.

Source files
------------

// File: rtl/ewrapper_pkg.sv
// ---------------------------------------------------------------------------
// ewrapper_pkg
// Shared definitions for the two-requester emesh arbiter:
//   - arbiter state encoding
//   - 103-bit emesh packet layout (write, datamode, ctrlmode, dst, src, data)
//   - burst counter width / saturation value and legal BURST_MAX bounds
//   - saturating increment helper for the burst counter
// ---------------------------------------------------------------------------
package ewrapper_pkg;

  localparam int DATAMODE_W = 2;
  localparam int CTRLMODE_W = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int PKT_W      = 1 + DATAMODE_W + CTRLMODE_W + 2 * ADDR_W + DATA_W;

  localparam int BURST_MAX_MIN = 1;
  localparam int BURST_MAX_MAX = 15;

  localparam int              CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_SAT = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [DATAMODE_W-1:0] datamode;
    logic [CTRLMODE_W-1:0] ctrlmode;
    logic [ADDR_W-1:0]     dstaddr;
    logic [ADDR_W-1:0]     srcaddr;
    logic [DATA_W-1:0]     data;
  } emesh_pkt_t;

  // Burst counter never wraps; it sticks at CNT_SAT.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + 4'd1;
  endfunction

endpackage

// File: rtl/ewrapper_emesh_arbiter_rr_grant.sv
// ---------------------------------------------------------------------------
// ewrapper_rr_grant
// Purely combinational grant selection for the two-requester arbiter.
// Ports:
//   state      in  current arbiter state (IDLE / OWN0 / OWN1)
//   cnt        in  consecutive grants given to the current owner
//   last_owner in  requester that won the most recent transfer
//   access0/1  in  requester packet-valid strobes
//   grant[1:0] out one-hot (or zero) grant; bit N selects requester N
// Grant does not consider slot occupancy; the top qualifies it with
// slot_free to form the actual accept.
// ---------------------------------------------------------------------------
module ewrapper_rr_grant
  import ewrapper_pkg::*;
#(
  parameter int unsigned BURST_MAX = 8
) (
  input  arb_state_e        state,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              last_owner,
  input  logic              access0,
  input  logic              access1,
  output logic [1:0]        grant
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  always_comb begin
    grant = 2'b00;
    case (state)
      ST_IDLE: begin
        // Tie goes to whoever did not own the link last.
        if (access0 && access1) begin
          grant = last_owner ? 2'b01 : 2'b10;
        end else begin
          grant = {access1, access0};
        end
      end
      ST_OWN0: begin
        // Owner keeps the link until its burst budget is spent, but only
        // yields if the other side actually wants it.
        if (access0 && ((cnt < BURST_LIM) || !access1)) begin
          grant = 2'b01;
        end else if (access1) begin
          grant = 2'b10;
        end
      end
      ST_OWN1: begin
        if (access1 && ((cnt < BURST_LIM) || !access0)) begin
          grant = 2'b10;
        end else if (access0) begin
          grant = 2'b01;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ewrapper_emesh_arbiter.sv
// ---------------------------------------------------------------------------
// ewrapper_emesh_arbiter
// Merges two emesh packet streams onto one link transmitter through a
// single registered output slot. Round-robin with a burst allowance of
// BURST_MAX consecutive transfers while the other side is waiting.
//
// Ports:
//   emesh_clk_inb            in   sole clock
//   reset                    in   synchronous active-high reset
//   reqN_access              in   requester N packet valid (held until accepted)
//   reqN_write/datamode/ctrlmode/dstaddr/srcaddr/data
//                            in   requester N packet fields
//   reqN_wr_wait/rd_wait     out  requester N stall (both = !accept_N)
//   emesh_*_outb             out  registered packet to the link transmitter
//   emesh_wr_wait_inb        in   link stall for write packets
//   emesh_rd_wait_inb        in   link stall for read packets
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no current owner; tie broken against last_owner
// OWN0    | requester 0 won the last accept; cnt counts its burst
// OWN1    | requester 1 won the last accept; cnt counts its burst
//
// The slot drains and refills in the same cycle, so a continuous stream
// moves one packet per cycle. The wait outputs are combinational from
// the link wait inputs through slot_free.
// ---------------------------------------------------------------------------
module ewrapper_emesh_arbiter
  import ewrapper_pkg::*;
#(
  parameter int unsigned BURST_MAX = 8
) (
  input  logic                  emesh_clk_inb,
  input  logic                  reset,

  input  logic                  req0_access,
  input  logic                  req0_write,
  input  logic [DATAMODE_W-1:0] req0_datamode,
  input  logic [CTRLMODE_W-1:0] req0_ctrlmode,
  input  logic [ADDR_W-1:0]     req0_dstaddr,
  input  logic [ADDR_W-1:0]     req0_srcaddr,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_wr_wait,
  output logic                  req0_rd_wait,

  input  logic                  req1_access,
  input  logic                  req1_write,
  input  logic [DATAMODE_W-1:0] req1_datamode,
  input  logic [CTRLMODE_W-1:0] req1_ctrlmode,
  input  logic [ADDR_W-1:0]     req1_dstaddr,
  input  logic [ADDR_W-1:0]     req1_srcaddr,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_wr_wait,
  output logic                  req1_rd_wait,

  output logic                  emesh_access_outb,
  output logic                  emesh_write_outb,
  output logic [DATAMODE_W-1:0] emesh_datamode_outb,
  output logic [CTRLMODE_W-1:0] emesh_ctrlmode_outb,
  output logic [ADDR_W-1:0]     emesh_dstaddr_outb,
  output logic [ADDR_W-1:0]     emesh_srcaddr_outb,
  output logic [DATA_W-1:0]     emesh_data_outb,
  input  logic                  emesh_wr_wait_inb,
  input  logic                  emesh_rd_wait_inb
);

  emesh_pkt_t        slot_q, slot_d;
  logic              slot_valid_q, slot_valid_d;
  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_owner_q, last_owner_d;

  emesh_pkt_t        req0_pkt;
  emesh_pkt_t        req1_pkt;
  logic              drain;
  logic              slot_free;
  logic [1:0]        grant;
  logic              accept0;
  logic              accept1;

  assign req0_pkt = {req0_write, req0_datamode, req0_ctrlmode,
                     req0_dstaddr, req0_srcaddr, req0_data};
  assign req1_pkt = {req1_write, req1_datamode, req1_ctrlmode,
                     req1_dstaddr, req1_srcaddr, req1_data};

  // The stall that matters depends on the kind of packet sitting in the slot.
  assign drain     = slot_valid_q &&
                     !(slot_q.write ? emesh_wr_wait_inb : emesh_rd_wait_inb);
  assign slot_free = !slot_valid_q || drain;

  ewrapper_rr_grant #(
    .BURST_MAX (BURST_MAX)
  ) u_grant (
    .state      (state_q),
    .cnt        (cnt_q),
    .last_owner (last_owner_q),
    .access0    (req0_access),
    .access1    (req1_access),
    .grant      (grant)
  );

  assign accept0 = grant[0] && slot_free;
  assign accept1 = grant[1] && slot_free;

  assign req0_wr_wait = !accept0;
  assign req0_rd_wait = !accept0;
  assign req1_wr_wait = !accept1;
  assign req1_rd_wait = !accept1;

  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;

    if (accept0) begin
      slot_d       = req0_pkt;
      slot_valid_d = 1'b1;
      state_d      = ST_OWN0;
      last_owner_d = 1'b0;
      cnt_d        = (state_q == ST_OWN0) ? cnt_sat_inc(cnt_q) : 4'd1;
    end else if (accept1) begin
      slot_d       = req1_pkt;
      slot_valid_d = 1'b1;
      state_d      = ST_OWN1;
      last_owner_d = 1'b1;
      cnt_d        = (state_q == ST_OWN1) ? cnt_sat_inc(cnt_q) : 4'd1;
    end else begin
      if (drain) begin
        slot_valid_d = 1'b0;
      end
      // With room in the slot and still no accept, nobody is requesting:
      // drop ownership. A full slot freezes ownership and the burst count.
      if (slot_free) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge emesh_clk_inb) begin
    if (reset) begin
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
    end else begin
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign emesh_access_outb   = slot_valid_q;
  assign emesh_write_outb    = slot_q.write;
  assign emesh_datamode_outb = slot_q.datamode;
  assign emesh_ctrlmode_outb = slot_q.ctrlmode;
  assign emesh_dstaddr_outb  = slot_q.dstaddr;
  assign emesh_srcaddr_outb  = slot_q.srcaddr;
  assign emesh_data_outb     = slot_q.data;

endmodule
